// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type, S-box and GF(2^8) helpers.
package aes_pkg;

    localparam int         AES_ROUNDS = 10;
    localparam logic [3:0] LAST_RND   = 4'(AES_ROUNDS);
    localparam logic [7:0] RCON_INIT  = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } aes_state_t;

    // Entry 0 sits in the top byte; entry b lives at bit offset (255-b)*8.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion step: current round key plus rcon -> next round key.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] rk_in,
    input  logic [7:0]   rcon,
    output logic [127:0] rk_out
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] n0, n1, n2, n3;
    logic [31:0] sub_rot;

    assign w0 = rk_in[127:96];
    assign w1 = rk_in[95:64];
    assign w2 = rk_in[63:32];
    assign w3 = rk_in[31:0];

    // SubWord(RotWord(w3)): rotate left one byte before substitution.
    assign sub_rot = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};

    assign n0 = w0 ^ sub_rot ^ {rcon, 24'h0};
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign rk_out = {n0, n1, n2, n3};

endmodule

// File: rtl/mix_columns.sv
// MixColumns: each 32-bit column multiplied by the fixed {02,03,01,01} circulant.
module mix_columns
    import aes_pkg::*;
(
    input  logic [127:0] din,
    output logic [127:0] dout
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;

        assign a0 = din[127 - 32*c      -: 8];
        assign a1 = din[127 - 32*c - 8  -: 8];
        assign a2 = din[127 - 32*c - 16 -: 8];
        assign a3 = din[127 - 32*c - 24 -: 8];

        assign dout[127 - 32*c      -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign dout[127 - 32*c - 8  -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign dout[127 - 32*c - 16 -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign dout[127 - 32*c - 24 -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

endmodule

// File: rtl/shift_rows.sv
// ShiftRows: row r of the column-major state rotates left by r bytes.
module shift_rows (
    input  logic [127:0] din,
    output logic [127:0] dout
);

    // Byte index r+4c lives at bits [127-8*(r+4c) -: 8].
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign dout[127 - 8*(r + 4*c) -: 8] = din[127 - 8*(r + 4*((c + r) % 4)) -: 8];
        end
    end

endmodule

// File: rtl/sub_bytes.sv
// SubBytes: independent S-box substitution of all 16 state bytes.
module sub_bytes
    import aes_pkg::*;
(
    input  logic [127:0] din,
    output logic [127:0] dout
);

    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign dout[8*i +: 8] = sbox(din[8*i +: 8]);
    end

endmodule

// File: rtl/aes_128_seq.sv
// Iterative AES-128 encryptor, one round per clock, key expanded on the fly.
// Optional AES_SEQ_B2B_EN lets a new block be accepted on the output handshake edge.
module aes_128_seq
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    // state    | meaning
    // ST_IDLE  | waiting for a block, in_ready high
    // ST_ROUND | one AES round per cycle, rnd runs 1..10
    // ST_DONE  | ciphertext held on out_data until out_ready

    aes_state_t   state, state_next;
    logic [127:0] state_reg, rk_reg, rk_next;
    logic [127:0] sb_out, sr_out, mc_out, round_out;
    logic [7:0]   rcon;
    logic [3:0]   rnd;
    logic         last_round;
    logic         accept;

    sub_bytes u_sub_bytes (
        .din  (state_reg),
        .dout (sb_out)
    );

    shift_rows u_shift_rows (
        .din  (sb_out),
        .dout (sr_out)
    );

    mix_columns u_mix_columns (
        .din  (sr_out),
        .dout (mc_out)
    );

    aes_key_step u_key_step (
        .rk_in  (rk_reg),
        .rcon   (rcon),
        .rk_out (rk_next)
    );

    assign last_round = (rnd == LAST_RND);
    assign round_out  = (last_round ? sr_out : mc_out) ^ rk_next;
    assign accept     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_next = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (last_round) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
`ifdef AES_SEQ_B2B_EN
                in_ready = out_ready;
                if (out_ready) begin
                    state_next = in_valid ? ST_ROUND : ST_IDLE;
                end
`else
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
`endif
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Acceptance has priority so a back-to-back load out of DONE restarts cleanly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= '0;
            rk_reg    <= '0;
            rcon      <= '0;
            rnd       <= '0;
            out_data  <= '0;
        end else if (accept) begin
            state_reg <= in_data ^ in_key;
            rk_reg    <= in_key;
            rcon      <= RCON_INIT;
            rnd       <= 4'd1;
        end else if (state == ST_ROUND) begin
            state_reg <= round_out;
            rk_reg    <= rk_next;
            if (last_round) begin
                out_data <= round_out;
            end else begin
                rnd  <= rnd + 4'd1;
                rcon <= xtime(rcon);
            end
        end
    end

endmodule

// File: tb/tb_aes_128_seq.sv
// Bench for aes_128_seq: transaction model built from GF(2^8) arithmetic plus known-answer vectors.
module tb_aes_128_seq;

`ifdef AES_SEQ_B2B_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    aes_128_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Reference cipher from field arithmetic; S-box derived from inverse + affine map.
    logic [7:0] sb_tab [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] v;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            v = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb_tab[x] = v;
        end
    endtask

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]   s [16];
        logic [7:0]   k [16];
        logic [7:0]   t [16];
        logic [7:0]   rc = 8'h01;
        logic [7:0]   a0, a1, a2, a3;
        logic [7:0]   k12, k13, k14, k15;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            k[i] = key[127 - 8*i -: 8];
            s[i] = pt[127 - 8*i -: 8] ^ k[i];
        end
        for (int r = 1; r <= 10; r++) begin
            k12 = k[12]; k13 = k[13]; k14 = k[14]; k15 = k[15];
            k[0] = k[0] ^ sb_tab[k13] ^ rc;
            k[1] = k[1] ^ sb_tab[k14];
            k[2] = k[2] ^ sb_tab[k15];
            k[3] = k[3] ^ sb_tab[k12];
            for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
            rc = gmul(rc, 8'h02);
            for (int row = 0; row < 4; row++)
                for (int c = 0; c < 4; c++)
                    t[row + 4*c] = sb_tab[s[row + 4*((c + row) % 4)]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r < 10) begin
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    // Transaction model: a block in flight completes 10 edges after acceptance.
    bit           m_started = 1'b0;
    bit           m_active  = 1'b0;
    bit           m_valid   = 1'b0;
    int           m_cnt     = 0;
    logic [127:0] m_result  = '0;
    logic [127:0] m_out     = '0;

    always @(posedge clk) begin
        bit exp_rdy, acc, hs;
        if (!rst_n) begin
            m_active = 1'b0;
            m_valid  = 1'b0;
            m_out    = '0;
        end else begin
            exp_rdy = !m_active || (B2B && m_valid && out_ready);
            hs      = m_valid && out_ready;
            acc     = in_valid && exp_rdy;
            if (hs) begin
                m_valid  = 1'b0;
                m_active = 1'b0;
            end
            if (acc) begin
                m_active = 1'b1;
                m_cnt    = 0;
                m_result = ref_encrypt(in_data, in_key);
            end else if (m_active && !m_valid) begin
                m_cnt++;
                if (m_cnt == 10) begin
                    m_valid = 1'b1;
                    m_out   = m_result;
                end
            end
        end
        m_started = 1'b1;
    end

    always @(negedge clk) begin
        if (m_started) begin
            check_bit("cyc out_valid", out_valid, m_valid);
            check_bit("cyc busy", busy, m_active);
            check_bit("cyc in_ready", in_ready, !m_active || (B2B && m_valid && out_ready));
            check("cyc out_data", out_data, m_out);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] pt, input logic [127:0] key);
        bit ok = 1'b0;
        in_data  = pt;
        in_key   = key;
        in_valid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            step();
        end
        in_valid = 1'b0;
        check_bit("accept seen", ok, 1'b1);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic finish_out();
        out_ready = 1'b1;
        step();
        check_bit("valid cleared on handshake", out_valid, 1'b0);
        out_ready = 1'b0;
    endtask

    task automatic run_vec(input string name, input logic [127:0] pt, input logic [127:0] key,
                           input logic [127:0] ct, input int hold);
        int lat;
        send(pt, key);
        wait_out(lat);
        check_int({name, " latency"}, lat, 10);
        check({name, " ciphertext"}, out_data, ct);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'(i % 2);
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            step();
            check({name, " held data"}, out_data, ct);
            check_bit({name, " held valid"}, out_valid, 1'b1);
            check_bit({name, " held in_ready"}, in_ready, 1'b0);
        end
        in_valid = 1'b0;
        finish_out();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int acc_e [2];
        int hs_e  [2];
        int val_e [2];
        int na = 0, nh = 0, nv = 0;
        bit prev_v;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        in_key    = '0;
        build_sbox();

        check("model pin A", ref_encrypt(PT_A, KEY_A), CT_A);
        check("model pin B", ref_encrypt(PT_B, KEY_B), CT_B);
        check("model pin zero", ref_encrypt('0, '0), CT_Z);

        repeat (3) step();
        check_bit("reset in_ready", in_ready, 1'b1);
        check_bit("reset out_valid", out_valid, 1'b0);
        check_bit("reset busy", busy, 1'b0);
        check("reset out_data", out_data, '0);
        rst_n = 1'b1;
        step();

        run_vec("vec A", PT_A, KEY_A, CT_A, 0);
        run_vec("vec B", PT_B, KEY_B, CT_B, 0);
        run_vec("vec zero", '0, '0, CT_Z, 20);

        // Reset while round 5 is in progress.
        send(PT_A, KEY_A);
        repeat (4) step();
        check_bit("mid-op busy", busy, 1'b1);
        rst_n = 1'b0;
        step();
        check_bit("mid-op reset out_valid", out_valid, 1'b0);
        check_bit("mid-op reset in_ready", in_ready, 1'b1);
        check_bit("mid-op reset busy", busy, 1'b0);
        rst_n = 1'b1;
        repeat (12) step();
        check_bit("no output after abandon", out_valid, 1'b0);
        run_vec("after reset vec B", PT_B, KEY_B, CT_B, 0);

        // Inputs churn while the block is in flight.
        send(PT_A, KEY_A);
        lat = 0;
        while (!out_valid && lat < 40) begin
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            in_key   = {$urandom, $urandom, $urandom, $urandom};
            in_valid = 1'($urandom_range(0, 1));
            step();
            lat++;
        end
        in_valid = 1'b0;
        check_int("toggle latency", lat, 10);
        check("toggle ciphertext", out_data, CT_A);
        finish_out();

        // Two blocks offered back to back with the consumer always ready.
        in_data   = PT_A;
        in_key    = KEY_A;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        prev_v    = out_valid;
        for (int c = 1; c <= 60 && nh < 2; c++) begin
            bit acc, hs;
            @(negedge clk);
            acc = in_valid && in_ready;
            hs  = out_valid && out_ready;
            step();
            if (hs && nh < 2) begin
                hs_e[nh] = c;
                nh++;
            end
            if (acc && na < 2) begin
                acc_e[na] = c;
                na++;
                if (na == 1) begin
                    in_data = PT_B;
                    in_key  = KEY_B;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid && !prev_v && nv < 2) begin
                val_e[nv] = c;
                nv++;
                check(nv == 1 ? "b2b first data" : "b2b second data", out_data, nv == 1 ? CT_A : CT_B);
            end
            prev_v = out_valid;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_int("b2b handshakes", nh, 2);
        check_int("b2b outputs", nv, 2);
        check_int("b2b first latency", val_e[0] - acc_e[0], 10);
        check_int("b2b second latency", val_e[1] - acc_e[1], 10);
        check_int("b2b accept after handshake", acc_e[1] - hs_e[0], B2B ? 0 : 1);
        check_int("b2b output spacing", val_e[1] - hs_e[0], B2B ? 10 : 11);
        repeat (2) step();
        check_bit("final idle", in_ready, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
